// File: rtl/mlp_axis_bridge_if.sv
// ============================================================================
// Module   : mlp_axis_bridge_if
// Purpose  : Bundles the host register bus and the two AXI-Stream ports of the
//            MLP control bridge.
//            - slave  : the bridge's view (bus target, TX stream source,
//                       RX stream sink).
//            - master : the environment's view (bus host, NoC side).
// Ports    : address/chipselect/read/write/writedata/readdata/irq (bus),
//            m_axis_* (TX stream), s_axis_* (RX stream).
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

interface mlp_axis_bridge_if #(
  parameter int DATAW = 128,
  parameter int DESTW = 12,
  parameter int USERW = 75
);
  // Host bus
  logic [5:0]       address;
  logic             chipselect;
  logic             read;
  logic             write;
  logic [31:0]      writedata;
  logic [31:0]      readdata;
  logic             irq;

  // TX stream towards the NoC
  logic             m_axis_tvalid;
  logic             m_axis_tready;
  logic [DATAW-1:0] m_axis_tdata;
  logic [DESTW-1:0] m_axis_tdest;
  logic [USERW-1:0] m_axis_tuser;
  logic             m_axis_tlast;

  // RX stream from the NoC (tlast/tuser/tdest are not carried: unused)
  logic             s_axis_tvalid;
  logic             s_axis_tready;
  logic [DATAW-1:0] s_axis_tdata;

  modport slave (
    input  address, chipselect, read, write, writedata,
    output readdata, irq,
    output m_axis_tvalid, m_axis_tdata, m_axis_tdest, m_axis_tuser, m_axis_tlast,
    input  m_axis_tready,
    input  s_axis_tvalid, s_axis_tdata,
    output s_axis_tready
  );

  modport master (
    output address, chipselect, read, write, writedata,
    input  readdata, irq,
    input  m_axis_tvalid, m_axis_tdata, m_axis_tdest, m_axis_tuser, m_axis_tlast,
    output m_axis_tready,
    output s_axis_tvalid, s_axis_tdata,
    input  s_axis_tready
  );
endinterface

`default_nettype wire

// File: rtl/mlp_axis_bridge.sv
// ============================================================================
// Module   : mlp_axis_bridge
// Purpose  : Memory-mapped bridge between the host bus and the MVM NoC.
//            Assembles DATAW-bit payloads from 32-bit register writes, sends
//            them as single-beat AXIS packets and buffers returned beats in
//            an RX_DEPTH-entry FIFO readable over the bus.
// Ports    : clk   - single clock for bus and streams
//            reset - asynchronous, active-high
//            bus   - mlp_axis_bridge_if.slave (register bus, TX and RX AXIS)
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module mlp_axis_bridge #(
  parameter int DATAW           = 128,
  parameter int DESTW           = 12,
  parameter int USERW           = 75,
  parameter int RX_DEPTH        = 4,
  parameter int RX_BACKPRESSURE = 1
) (
  input  logic             clk,
  input  logic             reset,
  mlp_axis_bridge_if.slave bus
);

  localparam int NW = DATAW / 32;
  localparam int PW = (RX_DEPTH > 1) ? $clog2(RX_DEPTH) : 1;
  localparam int CW = $clog2(RX_DEPTH + 1);
  localparam logic [CW-1:0] FULL_CNT = CW'(RX_DEPTH);

  typedef enum logic [0:0] {
    ST_IDLE = 1'b0,
    ST_SEND = 1'b1
  } tx_state_e;

  // --------------------------------------------------------------------------
  // State
  // --------------------------------------------------------------------------
  tx_state_e        state_q, state_d;
  logic [1:0]       op_q, op_d;
  logic             irq_en_q, irq_en_d;
  logic [DESTW-1:0] dest_q, dest_d;
  logic [8:0]       user_q, user_d;
  logic [31:0]      instr_q, instr_d;
  logic [DATAW-1:0] tx_words_q, tx_words_d;

  logic             tvalid_q, tvalid_d;
  logic [DATAW-1:0] tdata_q, tdata_d;
  logic [DESTW-1:0] tdest_q, tdest_d;
  logic [USERW-1:0] tuser_q, tuser_d;
  logic             tlast_q, tlast_d;

  logic [DATAW-1:0] mem_q [RX_DEPTH];
  logic [DATAW-1:0] mem_d [RX_DEPTH];
  logic [PW-1:0]    wr_ptr_q, wr_ptr_d;
  logic [PW-1:0]    rd_ptr_q, rd_ptr_d;
  logic [CW-1:0]    count_q, count_d;
  logic             ovf_q, ovf_d;
  logic             s_tready_q, s_tready_d;
  logic             irq_q, irq_d;
  logic [31:0]      readdata_q, readdata_d;

  // --------------------------------------------------------------------------
  // Decode
  // --------------------------------------------------------------------------
  logic        wr_en, rd_en;
  logic        send_req, flush_req;
  logic        rx_full, rx_empty;
  logic        pop, push_hs, store, drop;
  logic [31:0] status;

  always_comb begin
    wr_en     = bus.chipselect & bus.write;
    rd_en     = bus.chipselect & bus.read;
    send_req  = wr_en && (bus.address == 6'h00) && bus.writedata[0];
    flush_req = wr_en && (bus.address == 6'h00) && bus.writedata[4];
    rx_full   = (count_q == FULL_CNT);
    rx_empty  = (count_q == '0);
    // Reading the last word of the head entry retires that entry.
    pop       = rd_en && (bus.address == 6'(32 + NW - 1)) && !rx_empty;
    push_hs   = bus.s_axis_tvalid & s_tready_q;
    // When full, a beat is only storable if a pop frees the head this cycle.
    store     = push_hs && (!rx_full || pop);
    drop      = push_hs && rx_full && !pop;

    status         = '0;
    status[0]      = (state_q == ST_SEND);
    status[1]      = !rx_empty;
    status[2]      = rx_full;
    status[3]      = ovf_q;
    status[8 +: CW] = count_q;
  end

  // --------------------------------------------------------------------------
  // Register file and RX FIFO next-state
  // --------------------------------------------------------------------------
  always_comb begin
    op_d       = op_q;
    irq_en_d   = irq_en_q;
    dest_d     = dest_q;
    user_d     = user_q;
    instr_d    = instr_q;
    tx_words_d = tx_words_q;
    ovf_d      = ovf_q;
    mem_d      = mem_q;
    wr_ptr_d   = wr_ptr_q;
    rd_ptr_d   = rd_ptr_q;
    count_d    = count_q;

    if (wr_en) begin
      case (bus.address)
        6'h00: begin
          op_d     = bus.writedata[2:1];
          irq_en_d = bus.writedata[3];
        end
        6'h01:   dest_d  = bus.writedata[DESTW-1:0];
        6'h02:   user_d  = bus.writedata[8:0];
        6'h03:   if (bus.writedata[3]) ovf_d = 1'b0;
        6'h04:   instr_d = bus.writedata;
        default: begin
          for (int i = 0; i < NW; i++) begin
            if (bus.address == 6'(16 + i)) tx_words_d[32*i +: 32] = bus.writedata;
          end
        end
      endcase
    end

    if (flush_req) begin
      // Flush wins over any same-cycle push or pop.
      wr_ptr_d = '0;
      rd_ptr_d = '0;
      count_d  = '0;
    end else begin
      if (store) begin
        mem_d[wr_ptr_q] = bus.s_axis_tdata;
        wr_ptr_d        = wr_ptr_q + PW'(1);
      end
      if (pop) rd_ptr_d = rd_ptr_q + PW'(1);
      count_d = count_q + CW'(store) - CW'(pop);
      // Overflow set takes priority over a same-cycle software clear.
      if (drop) ovf_d = 1'b1;
    end

    s_tready_d = (RX_BACKPRESSURE != 0) ? (count_d != FULL_CNT) : 1'b1;
    irq_d      = irq_en_d & (count_d != '0);
  end

  // --------------------------------------------------------------------------
  // Read data: registered, holds between reads
  // --------------------------------------------------------------------------
  always_comb begin
    readdata_d = readdata_q;
    if (rd_en) begin
      readdata_d = '0;
      case (bus.address)
        6'h00:   readdata_d = {27'd0, 1'b0, irq_en_q, op_q, 1'b0};
        6'h01:   readdata_d = 32'(dest_q);
        6'h02:   readdata_d = 32'(user_q);
        6'h03:   readdata_d = status;
        6'h04:   readdata_d = instr_q;
        default: begin
          for (int i = 0; i < NW; i++) begin
            if (bus.address == 6'(16 + i)) readdata_d = tx_words_q[32*i +: 32];
            if ((bus.address == 6'(32 + i)) && !rx_empty)
              readdata_d = mem_q[rd_ptr_q][32*i +: 32];
          end
        end
      endcase
    end
  end

  // --------------------------------------------------------------------------
  // TX FSM next-state
  // --------------------------------------------------------------------------
  always_comb begin
    state_d  = state_q;
    tvalid_d = tvalid_q;
    tdata_d  = tdata_q;
    tdest_d  = tdest_q;
    tuser_d  = tuser_q;
    tlast_d  = tlast_q;
    case (state_q)
      ST_IDLE: begin
        if (send_req) begin
          // OP comes from the launching write itself; payload sources are
          // the values registered before this write.
          state_d       = ST_SEND;
          tvalid_d      = 1'b1;
          tlast_d       = 1'b1;
          tdest_d       = dest_q;
          tuser_d       = '0;
          tuser_d[10:9] = bus.writedata[2:1];
          tuser_d[8:0]  = user_q;
          tdata_d       = (bus.writedata[2:1] == 2'd0) ? DATAW'(instr_q) : tx_words_q;
        end
      end
      ST_SEND: begin
        if (bus.m_axis_tready) begin
          state_d  = ST_IDLE;
          tvalid_d = 1'b0;
          tdata_d  = '0;
          tlast_d  = 1'b0;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  // --------------------------------------------------------------------------
  // Flops
  // --------------------------------------------------------------------------
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q    <= ST_IDLE;
      op_q       <= '0;
      irq_en_q   <= 1'b0;
      dest_q     <= '0;
      user_q     <= '0;
      instr_q    <= '0;
      tx_words_q <= '0;
      tvalid_q   <= 1'b0;
      tdata_q    <= '0;
      tdest_q    <= '0;
      tuser_q    <= '0;
      tlast_q    <= 1'b0;
      for (int i = 0; i < RX_DEPTH; i++) mem_q[i] <= '0;
      wr_ptr_q   <= '0;
      rd_ptr_q   <= '0;
      count_q    <= '0;
      ovf_q      <= 1'b0;
      s_tready_q <= 1'b0;
      irq_q      <= 1'b0;
      readdata_q <= '0;
    end else begin
      state_q    <= state_d;
      op_q       <= op_d;
      irq_en_q   <= irq_en_d;
      dest_q     <= dest_d;
      user_q     <= user_d;
      instr_q    <= instr_d;
      tx_words_q <= tx_words_d;
      tvalid_q   <= tvalid_d;
      tdata_q    <= tdata_d;
      tdest_q    <= tdest_d;
      tuser_q    <= tuser_d;
      tlast_q    <= tlast_d;
      mem_q      <= mem_d;
      wr_ptr_q   <= wr_ptr_d;
      rd_ptr_q   <= rd_ptr_d;
      count_q    <= count_d;
      ovf_q      <= ovf_d;
      s_tready_q <= s_tready_d;
      irq_q      <= irq_d;
      readdata_q <= readdata_d;
    end
  end

  // --------------------------------------------------------------------------
  // Outputs: all straight from flops
  // --------------------------------------------------------------------------
  assign bus.readdata      = readdata_q;
  assign bus.irq           = irq_q;
  assign bus.m_axis_tvalid = tvalid_q;
  assign bus.m_axis_tdata  = tdata_q;
  assign bus.m_axis_tdest  = tdest_q;
  assign bus.m_axis_tuser  = tuser_q;
  assign bus.m_axis_tlast  = tlast_q;
  assign bus.s_axis_tready = s_tready_q;

endmodule

`default_nettype wire

// File: tb/tb_mlp_axis_bridge.sv
// ============================================================================
// Module   : tb_mlp_axis_bridge
// Purpose  : Self-checking bench for mlp_axis_bridge. Two instances are used:
//            one with RX backpressure, one in drop mode. A shared set of bus
//            and stream stimulus signals is steered to one of them by 'sel'.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_mlp_axis_bridge;

  localparam int DW    = 128;
  localparam int NW    = DW / 32;
  localparam int DEPTH = 4;

  logic clk   = 1'b0;
  logic reset = 1'b1;
  always #5 clk = ~clk;

  // Shared stimulus
  logic [5:0]    address  = '0;
  logic          cs       = 1'b0;
  logic          rd       = 1'b0;
  logic          wr       = 1'b0;
  logic [31:0]   wdata    = '0;
  logic          m_tready = 1'b0;
  logic          s_tvalid = 1'b0;
  logic [DW-1:0] s_tdata  = '0;
  logic          sel      = 1'b0;   // 0: backpressure DUT, 1: drop-mode DUT

  mlp_axis_bridge_if #(.DATAW(DW), .DESTW(12), .USERW(75)) ifb ();
  mlp_axis_bridge_if #(.DATAW(DW), .DESTW(12), .USERW(75)) ifd ();

  mlp_axis_bridge #(.DATAW(DW), .DESTW(12), .USERW(75), .RX_DEPTH(DEPTH),
                    .RX_BACKPRESSURE(1))
    dut_bp (.clk(clk), .reset(reset), .bus(ifb.slave));
  mlp_axis_bridge #(.DATAW(DW), .DESTW(12), .USERW(75), .RX_DEPTH(DEPTH),
                    .RX_BACKPRESSURE(0))
    dut_dr (.clk(clk), .reset(reset), .bus(ifd.slave));

  assign ifb.address       = address;
  assign ifb.chipselect    = cs & ~sel;
  assign ifb.read          = rd;
  assign ifb.write         = wr;
  assign ifb.writedata     = wdata;
  assign ifb.m_axis_tready = m_tready;
  assign ifb.s_axis_tvalid = s_tvalid & ~sel;
  assign ifb.s_axis_tdata  = s_tdata;
  assign ifd.address       = address;
  assign ifd.chipselect    = cs & sel;
  assign ifd.read          = rd;
  assign ifd.write         = wr;
  assign ifd.writedata     = wdata;
  assign ifd.m_axis_tready = m_tready;
  assign ifd.s_axis_tvalid = s_tvalid & sel;
  assign ifd.s_axis_tdata  = s_tdata;

  // Observed outputs of the selected DUT
  logic [31:0]   rdata;
  logic          irq, s_tready, m_tvalid, m_tlast;
  logic [DW-1:0] m_tdata;
  logic [11:0]   m_tdest;
  logic [74:0]   m_tuser;
  assign rdata    = sel ? ifd.readdata      : ifb.readdata;
  assign irq      = sel ? ifd.irq           : ifb.irq;
  assign s_tready = sel ? ifd.s_axis_tready : ifb.s_axis_tready;
  assign m_tvalid = sel ? ifd.m_axis_tvalid : ifb.m_axis_tvalid;
  assign m_tlast  = sel ? ifd.m_axis_tlast  : ifb.m_axis_tlast;
  assign m_tdata  = sel ? ifd.m_axis_tdata  : ifb.m_axis_tdata;
  assign m_tdest  = sel ? ifd.m_axis_tdest  : ifb.m_axis_tdest;
  assign m_tuser  = sel ? ifd.m_axis_tuser  : ifb.m_axis_tuser;

  int checks   = 0;
  int errors   = 0;
  int tx_xfers = 0;

  // Reference model of the selected DUT's RX side
  logic [DW-1:0] rxq[$];
  bit            ovf_m  = 1'b0;
  bit            busy_m = 1'b0;

  // Inputs are stable between #1-after-edge and the next edge, so a cycle
  // with both valid and ready at the falling edge is one transfer.
  always @(negedge clk) begin
    if (!reset && !sel && ifb.m_axis_tvalid && m_tready) tx_xfers++;
  end

  task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    checks++;
    assert (obs === exp)
    else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic bus_write(input logic [5:0] a, input logic [31:0] d);
    address = a; wdata = d; cs = 1'b1; wr = 1'b1;
    tick();
    cs = 1'b0; wr = 1'b0;
  endtask

  task automatic bus_read(input logic [5:0] a, output logic [31:0] d);
    address = a; cs = 1'b1; rd = 1'b1;
    tick();
    cs = 1'b0; rd = 1'b0;
    d = rdata;
  endtask

  function automatic logic [31:0] exp_status();
    logic [31:0] s;
    s       = '0;
    s[0]    = busy_m;
    s[1]    = (rxq.size() != 0);
    s[2]    = (rxq.size() == DEPTH);
    s[3]    = ovf_m;
    s[16:8] = 9'(rxq.size());
    return s;
  endfunction

  task automatic check_status(input string tag);
    logic [31:0] v;
    bus_read(6'h03, v);
    chk(tag, v, exp_status());
  endtask

  // One RX beat with no concurrent bus activity.
  task automatic rx_push(input logic [DW-1:0] d);
    logic exp_rdy;
    exp_rdy = sel ? 1'b1 : (rxq.size() < DEPTH);
    chk("s_tready", s_tready, exp_rdy);
    s_tvalid = 1'b1; s_tdata = d;
    tick();
    s_tvalid = 1'b0;
    if (rxq.size() < DEPTH) rxq.push_back(d);
    else if (sel) ovf_m = 1'b1;
  endtask

  // Read every word of the head entry; the final word pops it.
  task automatic rx_pop_check();
    logic [31:0]   v;
    logic [DW-1:0] f;
    f = (rxq.size() != 0) ? rxq[0] : '0;
    for (int i = 0; i < NW; i++) begin
      bus_read(6'(32 + i), v);
      chk($sformatf("rx_word%0d", i), v, f[32*i +: 32]);
    end
    if (rxq.size() != 0) void'(rxq.pop_front());
  endtask

  task automatic chk_tx(input logic [DW-1:0] d, input logic [11:0] dest,
                        input logic [1:0] op, input logic [8:0] user);
    logic [74:0] u;
    u = '0; u[10:9] = op; u[8:0] = user;
    chk("tvalid", m_tvalid, 1'b1);
    chk("tdata",  m_tdata, d);
    chk("tdest",  m_tdest, dest);
    chk("tuser",  m_tuser, u);
    chk("tlast",  m_tlast, 1'b1);
  endtask

  function automatic logic [DW-1:0] rnd_beat();
    logic [DW-1:0] r;
    for (int i = 0; i < NW; i++) r[32*i +: 32] = $urandom;
    return r;
  endfunction

  initial begin
    logic [31:0]   v;
    logic [31:0]   instr;
    logic [DW-1:0] words, d;
    logic [11:0]   dest;
    logic [8:0]    user;
    logic [1:0]    op;
    int            start;

    // ---------------- Reset ----------------
    repeat (3) @(posedge clk);
    #1;
    chk("rst_s_tready", s_tready, 1'b0);
    chk("rst_tvalid", m_tvalid, 1'b0);
    chk("rst_readdata", rdata, 32'd0);
    chk("rst_irq", irq, 1'b0);
    reset = 1'b0;
    tick();
    chk("post_rst_s_tready", s_tready, 1'b1);
    check_status("rst_status");

    // ---------------- TX instruction with stalled tready ----------------
    instr = 32'hDEADBEEF;
    bus_write(6'h04, instr);
    bus_write(6'h01, 32'd5);
    bus_write(6'h02, 32'h1A5);
    start = tx_xfers;
    bus_write(6'h00, 32'h1);
    busy_m = 1'b1;
    repeat (3) begin
      chk_tx(DW'(instr), 12'd5, 2'd0, 9'h1A5);
      tick();
    end
    check_status("busy_status");
    m_tready = 1'b1;
    tick();
    m_tready = 1'b0;
    busy_m   = 1'b0;
    chk("tx_done_tvalid", m_tvalid, 1'b0);
    chk("tx_done_tdata", m_tdata, '0);
    chk("tx_count", tx_xfers, start + 1);
    check_status("idle_status");

    // ---------------- TX packets: fixed OP=2 then randomized ----------------
    for (int k = 0; k < 5; k++) begin
      if (k == 0) begin
        words = {32'h44444444, 32'h33333333, 32'h22222222, 32'h11111111};
        op    = 2'd2;
      end else begin
        words = rnd_beat();
        op    = 2'($urandom_range(0, 3));
      end
      instr = $urandom;
      dest  = 12'($urandom_range(0, 4095));
      user  = 9'($urandom_range(0, 511));
      for (int i = 0; i < NW; i++) bus_write(6'(16 + i), words[32*i +: 32]);
      bus_write(6'h04, instr);
      bus_write(6'h01, 32'(dest));
      bus_write(6'h02, 32'(user));
      start = tx_xfers;
      bus_write(6'h00, {29'd0, op, 1'b1});
      d = (op == 2'd0) ? DW'(instr) : words;
      chk_tx(d, dest, op, user);
      // A second SEND and register updates while busy must not disturb it.
      bus_write(6'h00, {29'd0, ~op, 1'b1});
      bus_write(6'h10, $urandom);
      bus_write(6'h01, 32'(~dest));
      chk_tx(d, dest, op, user);
      m_tready = 1'b1;
      tick();
      m_tready = 1'b0;
      repeat (2) tick();
      chk("tx_idle", m_tvalid, 1'b0);
      chk("tx_one_xfer", tx_xfers, start + 1);
    end

    // ---------------- RX ordering with IRQ ----------------
    bus_write(6'h00, 32'h8);
    bus_read(6'h00, v);
    chk("ctrl_readback", v, 32'h8);
    bus_read(6'h05, v);
    chk("unmapped_read", v, 32'd0);
    repeat (3) rx_push(rnd_beat());
    bus_read(6'h03, v);
    chk("status_3beats", v, 32'h302);
    chk("irq_set", irq, 1'b1);
    repeat (3) rx_pop_check();
    check_status("rx_drained");
    chk("irq_clear", irq, 1'b0);

    // ---------------- Full with backpressure ----------------
    repeat (5) rx_push(rnd_beat());
    chk("bp_tready_full", s_tready, 1'b0);
    check_status("bp_full_status");
    rx_pop_check();
    chk("bp_tready_back", s_tready, 1'b1);
    rx_push(rnd_beat());
    repeat (4) rx_pop_check();
    check_status("bp_empty");

    // ---------------- Drop mode ----------------
    sel = 1'b1;
    repeat (6) rx_push(rnd_beat());
    check_status("drop_full_ovf");
    // Push concurrent with a popping read while full: beat is stored.
    d = rnd_beat();
    address = 6'(32 + NW - 1); cs = 1'b1; rd = 1'b1;
    s_tvalid = 1'b1; s_tdata = d;
    tick();
    cs = 1'b0; rd = 1'b0; s_tvalid = 1'b0;
    chk("pop_push_head", rdata, rxq[0][DW-1 -: 32]);
    void'(rxq.pop_front());
    rxq.push_back(d);
    check_status("pop_push_status");
    bus_write(6'h03, 32'h8);
    ovf_m = 1'b0;
    check_status("ovf_cleared");
    repeat (4) rx_pop_check();
    rx_pop_check();   // empty: reads return 0
    check_status("drop_empty");
    sel = 1'b0;

    // ---------------- Reset mid-packet ----------------
    repeat (2) rx_push(rnd_beat());
    bus_write(6'h04, $urandom);
    bus_write(6'h00, 32'h1);
    chk("pre_rst_tvalid", m_tvalid, 1'b1);
    reset = 1'b1;
    #1;
    chk("async_rst_tvalid", m_tvalid, 1'b0);
    chk("async_rst_tready", s_tready, 1'b0);
    rxq.delete();
    busy_m = 1'b0;
    tick();
    reset = 1'b0;
    tick();
    chk("rst2_tready", s_tready, 1'b1);
    check_status("rst2_status");
    bus_read(6'h01, v);
    chk("rst2_dest", v, 32'd0);

    // ---------------- Flush with same-cycle push ----------------
    repeat (2) rx_push(rnd_beat());
    address = 6'h00; wdata = 32'h10; cs = 1'b1; wr = 1'b1;
    s_tvalid = 1'b1; s_tdata = rnd_beat();
    tick();
    cs = 1'b0; wr = 1'b0; s_tvalid = 1'b0;
    rxq.delete();
    check_status("flush_status");
    rx_pop_check();
    rx_push(rnd_beat());
    rx_pop_check();
    check_status("post_flush_empty");

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

`default_nettype wire
